// File: rtl/pid_ctrl_pkg.sv
// Shared definitions for the pressure-loop sample sequencer: state encoding,
// overpressure limit, duty bit-slice and sample-period helper.
package pid_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REQ    = 3'd1,
    ST_LATCH  = 3'd2,
    ST_STROBE = 3'd3,
    ST_SETTLE = 3'd4,
    ST_APPLY  = 3'd5,
    ST_FAULT  = 3'd6
  } state_e;

  localparam logic [15:0] PRESSURE_MAX = 16'd4000;

  localparam int unsigned DUTY_MSB = 14;
  localparam int unsigned DUTY_LSB = 7;

  function automatic int unsigned calc_period(input int unsigned clk_hz,
                                              input int unsigned sample_hz);
    return clk_hz / sample_hz;
  endfunction

endpackage

// File: rtl/sample_tick_gen.sv
// Free-running sample-period counter; emits a one-cycle tick on the cycle the
// count wraps back to zero. Held at zero while clear_i is high.
module sample_tick_gen #(
  parameter int unsigned PERIOD = 10
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  output logic tick_o
);

  localparam int unsigned CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear_i || cnt_q == LAST) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = !clear_i && (cnt_q == LAST);

endmodule

// File: rtl/pid_sample_sequencer.sv
// Runs one ADC-read / PID-strobe / duty-update iteration per sample tick and
// owns PID reset, ADC timeout, overpressure and overrun detection.
module pid_sample_sequencer #(
  parameter int unsigned CLK_FREQ_HZ   = 100000000,
  parameter int unsigned SAMPLE_HZ     = 1000,
  parameter int unsigned ADC_TIMEOUT   = 1000,
  parameter int unsigned MAX_TIMEOUTS  = 3,
  parameter logic [15:0] PRESSURE_MAX  = pid_ctrl_pkg::PRESSURE_MAX,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic               CLK,
  input  logic               RESET_N,
  input  logic               ENABLE,
  output logic               ADC_REQ,
  input  logic               ADC_ACK,
  input  logic [15:0]        ADC_DATA,
  output logic [15:0]        PRESSURE_VALUE,
  output logic               PID_SAMPLE,
  output logic               PID_RESET,
  input  logic signed [15:0] PID_OUT,
  output logic [7:0]         DUTY,
  output logic               PUMP_EN,
  output logic               FAULT,
  output logic               OVERRUN
);
  import pid_ctrl_pkg::*;

  localparam int unsigned PERIOD = calc_period(CLK_FREQ_HZ, SAMPLE_HZ);
  localparam int unsigned WAIT_W = (ADC_TIMEOUT > 1) ? $clog2(ADC_TIMEOUT) : 1;
  localparam int unsigned TMO_W  = (MAX_TIMEOUTS > 1) ? $clog2(MAX_TIMEOUTS) : 1;
  localparam int unsigned SET_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST   = WAIT_W'(ADC_TIMEOUT - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST    = TMO_W'(MAX_TIMEOUTS - 1);
  localparam logic [SET_W-1:0]  SETTLE_LAST = SET_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [SET_W-1:0]  settle_q, settle_d;
  logic [15:0]       press_q, press_d;
  logic [7:0]        duty_q, duty_d;
  logic              overrun_q, overrun_d;
  logic              enable_q;
  logic              adc_req_q, pid_sample_q, pid_reset_q, pump_en_q, fault_q;
  logic              tick;
  logic              unused_pid_bits;

  assign unused_pid_bits = ^PID_OUT[DUTY_LSB-1:0];

  sample_tick_gen #(
    .PERIOD (PERIOD)
  ) u_tick (
    .clk_i   (CLK),
    .rst_ni  (RESET_N),
    .clear_i (!ENABLE || state_q == ST_FAULT),
    .tick_o  (tick)
  );

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    tmo_d     = tmo_q;
    settle_d  = settle_q;
    press_d   = press_q;
    duty_d    = duty_q;
    overrun_d = overrun_q;

    if (tick && state_q != ST_IDLE) begin
      overrun_d = 1'b1;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (tick) begin
          state_d = ST_REQ;
          wait_d  = '0;
        end
      end
      ST_REQ: begin
        // ACK takes priority over a timeout expiring in the same cycle
        if (ADC_ACK) begin
          if (ADC_DATA > PRESSURE_MAX) begin
            state_d = ST_FAULT;
          end else begin
            press_d = ADC_DATA;
            tmo_d   = '0;
            state_d = ST_LATCH;
          end
        end else if (wait_q == WAIT_LAST) begin
          if (tmo_q == TMO_LAST) begin
            state_d = ST_FAULT;
          end else begin
            tmo_d   = tmo_q + 1'b1;
            state_d = ST_IDLE;
          end
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      ST_LATCH:  state_d = ST_STROBE;
      ST_STROBE: begin
        settle_d = '0;
        state_d  = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (settle_q == SETTLE_LAST) begin
          state_d = ST_APPLY;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      ST_APPLY: begin
        duty_d  = PID_OUT[15] ? '0 : PID_OUT[DUTY_MSB:DUTY_LSB];
        state_d = ST_IDLE;
      end
      ST_FAULT: begin
        if (!ENABLE) begin
          state_d = ST_IDLE;
          tmo_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Abort overrides anything the iteration decided this cycle, including a capture
    if (!ENABLE && state_q != ST_FAULT) begin
      state_d = ST_IDLE;
      press_d = press_q;
      duty_d  = '0;
      tmo_d   = '0;
      if (enable_q) begin
        overrun_d = 1'b0;
      end
    end

    if (state_d == ST_FAULT) begin
      duty_d = '0;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q      <= ST_IDLE;
      wait_q       <= '0;
      tmo_q        <= '0;
      settle_q     <= '0;
      press_q      <= '0;
      duty_q       <= '0;
      overrun_q    <= 1'b0;
      enable_q     <= 1'b0;
      adc_req_q    <= 1'b0;
      pid_sample_q <= 1'b0;
      pid_reset_q  <= 1'b1;
      pump_en_q    <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_q       <= wait_d;
      tmo_q        <= tmo_d;
      settle_q     <= settle_d;
      press_q      <= press_d;
      duty_q       <= duty_d;
      overrun_q    <= overrun_d;
      enable_q     <= ENABLE;
      adc_req_q    <= (state_d == ST_REQ);
      pid_sample_q <= (state_d == ST_STROBE);
      pid_reset_q  <= (state_d == ST_FAULT) || !ENABLE;
      pump_en_q    <= ENABLE && (state_d != ST_FAULT);
      fault_q      <= (state_d == ST_FAULT);
    end
  end

  assign ADC_REQ        = adc_req_q;
  assign PRESSURE_VALUE = press_q;
  assign PID_SAMPLE     = pid_sample_q;
  assign PID_RESET      = pid_reset_q;
  assign DUTY           = duty_q;
  assign PUMP_EN        = pump_en_q;
  assign FAULT          = fault_q;
  assign OVERRUN        = overrun_q;

endmodule

// File: tb/tb_pid_sample_sequencer.sv
// Directed bench for pid_sample_sequencer: an ADC responder model, a strobe
// monitor that checks each iteration against a queue of expected results.
module tb_pid_sample_sequencer;

  logic               CLK = 1'b0;
  logic               RESET_N = 1'b0;
  logic               ENABLE = 1'b0;
  logic               ADC_REQ;
  logic               ADC_ACK = 1'b0;
  logic [15:0]        ADC_DATA = '0;
  logic [15:0]        PRESSURE_VALUE;
  logic               PID_SAMPLE;
  logic               PID_RESET;
  logic signed [15:0] PID_OUT = '0;
  logic [7:0]         DUTY;
  logic               PUMP_EN;
  logic               FAULT;
  logic               OVERRUN;

  pid_sample_sequencer #(
    .CLK_FREQ_HZ   (1000),
    .SAMPLE_HZ     (100),
    .ADC_TIMEOUT   (5),
    .MAX_TIMEOUTS  (3),
    .PRESSURE_MAX  (16'd4000),
    .SETTLE_CYCLES (2)
  ) dut (
    .CLK            (CLK),
    .RESET_N        (RESET_N),
    .ENABLE         (ENABLE),
    .ADC_REQ        (ADC_REQ),
    .ADC_ACK        (ADC_ACK),
    .ADC_DATA       (ADC_DATA),
    .PRESSURE_VALUE (PRESSURE_VALUE),
    .PID_SAMPLE     (PID_SAMPLE),
    .PID_RESET      (PID_RESET),
    .PID_OUT        (PID_OUT),
    .DUTY           (DUTY),
    .PUMP_EN        (PUMP_EN),
    .FAULT          (FAULT),
    .OVERRUN        (OVERRUN)
  );

  initial forever #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct packed {
    logic [15:0] press;
    logic [7:0]  duty;
  } exp_t;
  exp_t exp_q[$];
  logic mon_busy = 1'b0;
  int   strobe_last = 0;
  int   strobe_prev = 0;

  // ADC responder: ack on REQ cycle index ack_delay (0 = first REQ cycle)
  logic        ack_en = 1'b0;
  int          ack_delay = 1;
  logic [15:0] ack_data = '0;
  logic        force_ack = 1'b0;
  int          req_cnt = 0;

  always @(posedge CLK) begin
    #1;
    if (force_ack) begin
      ADC_ACK  = 1'b1;
      ADC_DATA = ack_data;
    end else if (ADC_REQ && ack_en) begin
      ADC_ACK = (req_cnt == ack_delay);
      if (req_cnt == ack_delay) ADC_DATA = ack_data;
      req_cnt++;
    end else begin
      ADC_ACK = 1'b0;
      req_cnt = 0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: got timeout expected event", name);
  endtask

  // Monitor: every strobe must match a queued iteration; duty checked 4 cycles later
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (RESET_N && PID_SAMPLE) begin
        strobe_prev = strobe_last;
        strobe_last = cyc;
        if (exp_q.size() == 0) begin
          check("unexpected_strobe", 32'(PID_SAMPLE), 32'd0);
        end else begin
          mon_busy = 1'b1;
          e = exp_q.pop_front();
          check("strobe_pressure", 32'(PRESSURE_VALUE), 32'(e.press));
          @(negedge CLK);
          check("strobe_width", 32'(PID_SAMPLE), 32'd0);
          repeat (3) @(negedge CLK);
          check("iter_duty", 32'(DUTY), 32'(e.duty));
          mon_busy = 1'b0;
        end
      end
    end
  end

  task automatic wait_mon_idle();
    int n = 0;
    while ((exp_q.size() != 0 || mon_busy) && n < 60) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 60) fail_now("iter_timeout");
  endtask

  task automatic run_iter(input int d, input logic [15:0] data,
                          input logic signed [15:0] pid, input logic [7:0] exp_duty);
    exp_t e;
    ack_en    = 1'b1;
    ack_delay = d;
    ack_data  = data;
    PID_OUT   = pid;
    e.press   = data;
    e.duty    = exp_duty;
    exp_q.push_back(e);
    wait_mon_idle();
  endtask

  // Returns at the first negedge after ADC_REQ falls; hi = cycles it was high
  task automatic req_window(output int hi);
    int n = 0;
    hi = 0;
    while (!ADC_REQ && n < 40) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 40) begin
      fail_now("req_rise");
    end else begin
      while (ADC_REQ && hi < 40) begin
        @(negedge CLK);
        hi++;
      end
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_adc_req"}, 32'(ADC_REQ), 32'd0);
    check({tag, "_pressure"}, 32'(PRESSURE_VALUE), 32'd0);
    check({tag, "_pid_sample"}, 32'(PID_SAMPLE), 32'd0);
    check({tag, "_pid_reset"}, 32'(PID_RESET), 32'd1);
    check({tag, "_duty"}, 32'(DUTY), 32'd0);
    check({tag, "_pump_en"}, 32'(PUMP_EN), 32'd0);
    check({tag, "_fault"}, 32'(FAULT), 32'd0);
    check({tag, "_overrun"}, 32'(OVERRUN), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got time limit expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi;
    int n;
    exp_t e;

    repeat (3) @(negedge CLK);
    check_reset_vals("reset");
    RESET_N = 1'b1;
    @(negedge CLK);

    // 1. nominal: ack on 2nd REQ cycle, 3200 -> duty 25, one iteration per 10 cycles
    ENABLE = 1'b1;
    run_iter(1, 16'd900, 16'sd3200, 8'd25);
    check("nom_pump_en", 32'(PUMP_EN), 32'd1);
    check("nom_pid_reset", 32'(PID_RESET), 32'd0);
    run_iter(1, 16'd900, 16'sd3200, 8'd25);
    check("nom_period", 32'(strobe_last - strobe_prev), 32'd10);

    // 2. negative and full-scale PID output
    run_iter(1, 16'd900, -16'sd500, 8'd0);
    run_iter(1, 16'd1000, 16'sh7FFF, 8'd255);

    // 3. timeouts, count reset by a good read, then fault on the third in a row
    ack_en = 1'b0;
    req_window(hi);
    check("tmo1_req_len", 32'(hi), 32'd5);
    check("tmo1_duty_held", 32'(DUTY), 32'd255);
    check("tmo1_press_held", 32'(PRESSURE_VALUE), 32'd1000);
    req_window(hi);
    check("tmo2_fault", 32'(FAULT), 32'd0);
    run_iter(1, 16'd500, 16'sd3200, 8'd25);
    ack_en = 1'b0;
    req_window(hi);
    req_window(hi);
    check("tmo_count_reset", 32'(FAULT), 32'd0);
    req_window(hi);
    check("tmo3_fault", 32'(FAULT), 32'd1);
    check("tmo3_pump_en", 32'(PUMP_EN), 32'd0);
    check("tmo3_duty", 32'(DUTY), 32'd0);

    // 4. overpressure
    ENABLE = 1'b0;
    repeat (2) @(negedge CLK);
    check("fault_exit", 32'(FAULT), 32'd0);
    ENABLE    = 1'b1;
    ack_en    = 1'b1;
    ack_delay = 1;
    ack_data  = 16'd4001;
    req_window(hi);
    check("ovp_req_len", 32'(hi), 32'd2);
    check("ovp_fault", 32'(FAULT), 32'd1);
    check("ovp_pid_reset", 32'(PID_RESET), 32'd1);
    repeat (15) @(negedge CLK);
    ENABLE = 1'b0;
    repeat (2) @(negedge CLK);
    check("ovp_fault_clear", 32'(FAULT), 32'd0);
    check("ovp_press_kept", 32'(PRESSURE_VALUE), 32'd500);
    ENABLE = 1'b1;
    run_iter(1, 16'd1200, 16'sd3200, 8'd25);

    // 5a. abort in REQ, late ACK ignored
    ack_en = 1'b0;
    n = 0;
    while (!ADC_REQ && n < 40) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 40) fail_now("abort_req_rise");
    ENABLE = 1'b0;
    @(negedge CLK);
    check("abort_adc_req", 32'(ADC_REQ), 32'd0);
    check("abort_duty", 32'(DUTY), 32'd0);
    check("abort_pump_en", 32'(PUMP_EN), 32'd0);
    check("abort_pid_reset", 32'(PID_RESET), 32'd1);
    ack_data  = 16'd777;
    force_ack = 1'b1;
    @(negedge CLK);
    force_ack = 1'b0;
    repeat (2) @(negedge CLK);
    check("late_ack_ignored", 32'(PRESSURE_VALUE), 32'd1200);

    // 5b. asynchronous reset during SETTLE
    ENABLE    = 1'b1;
    ack_en    = 1'b1;
    ack_delay = 1;
    ack_data  = 16'd900;
    PID_OUT   = 16'sd3200;
    e.press   = 16'd900;
    e.duty    = 8'd0;
    exp_q.push_back(e);
    n = 0;
    while (!PID_SAMPLE && n < 40) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 40) fail_now("settle_strobe");
    @(negedge CLK);
    RESET_N = 1'b0;
    ENABLE  = 1'b0;
    #1;
    check_reset_vals("midrst");
    @(negedge CLK);
    RESET_N = 1'b1;
    wait_mon_idle();

    // 6. late ACK stretches the iteration past the next tick
    ENABLE = 1'b1;
    @(negedge CLK);
    check("ovr_before", 32'(OVERRUN), 32'd0);
    run_iter(4, 16'd1500, 16'sd3200, 8'd25);
    check("ovr_set", 32'(OVERRUN), 32'd1);
    run_iter(1, 16'd1600, 16'sd3200, 8'd25);
    check("ovr_tick_dropped", 32'(strobe_last - strobe_prev), 32'd17);
    check("ovr_sticky", 32'(OVERRUN), 32'd1);
    ENABLE = 1'b0;
    repeat (2) @(negedge CLK);
    check("ovr_cleared", 32'(OVERRUN), 32'd0);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
